// File: rtl/display_timing_480p.sv
// display_timing_480p
//   Raster timing generator for a 640x480 @ 60 Hz style display (parameterisable).
//   Produces the current screen position together with sync, data-enable and
//   line/frame strobes. Every output is registered. The strobes and syncs are
//   computed from the next-state counters, so they line up exactly with the
//   sx/sy value presented in the same cycle.
//
// Ports
//   clk_pix   in   pixel clock
//   rst_pix   in   asynchronous active-high reset
//   sx, sy    out  horizontal / vertical screen position (CORDW bits)
//   hsync     out  horizontal sync, level H_POL during the pulse
//   vsync     out  vertical sync, level V_POL during the pulse
//   de        out  data enable, high inside the active area
//   frame     out  one-cycle strobe at (0, V_RES), the start of vertical blanking
//   line      out  one-cycle strobe at sx == 0 on every line
//   frame_cnt out  count of completed frames, wraps silently
module display_timing_480p #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_STA  = H_RES + H_FP;
  localparam int unsigned HS_END  = H_RES + H_FP + H_SYNC;
  localparam int unsigned VS_STA  = V_RES + V_FP;
  localparam int unsigned VS_END  = V_RES + V_FP + V_SYNC;
  localparam int unsigned H_ACT   = H_RES;
  localparam int unsigned V_ACT   = V_RES;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);

  localparam logic HP = (H_POL != 0);
  localparam logic VP = (V_POL != 0);

  // The counters must hold H_TOTAL-1 and V_TOTAL-1 without truncation.
  if (H_TOTAL > (2 ** CORDW) || V_TOTAL > (2 ** CORDW)) begin : g_cordw_check
    $error("display_timing_480p: CORDW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CORDW-1:0] sx_nxt;
  logic [CORDW-1:0] sy_nxt;
  logic [31:0]      hx;
  logic [31:0]      vy;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             de_nxt;
  logic             frame_nxt;
  logic             line_nxt;

  always_comb begin
    sx_nxt = sx + 1'b1;
    sy_nxt = sy;
    if (sx == H_LAST) begin
      sx_nxt = '0;
      sy_nxt = (sy == V_LAST) ? '0 : sy + 1'b1;
    end
  end

  // Decode against the next position, zero-extended so sync edges that
  // coincide with 2**CORDW still compare correctly.
  assign hx = 32'(sx_nxt);
  assign vy = 32'(sy_nxt);

  always_comb begin
    hsync_nxt = (hx >= HS_STA && hx < HS_END) ? HP : ~HP;
    vsync_nxt = (vy >= VS_STA && vy < VS_END) ? VP : ~VP;
    de_nxt    = (hx < H_ACT) && (vy < V_ACT);
    line_nxt  = (hx == 32'd0);
    frame_nxt = (hx == 32'd0) && (vy == V_ACT);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx        <= '0;
      sy        <= '0;
      hsync     <= ~HP;
      vsync     <= ~VP;
      de        <= 1'b0;
      frame     <= 1'b0;
      line      <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      sx    <= sx_nxt;
      sy    <= sy_nxt;
      hsync <= hsync_nxt;
      vsync <= vsync_nxt;
      de    <= de_nxt;
      frame <= frame_nxt;
      line  <= line_nxt;
      // Count lands on the same edge as the frame strobe.
      if (frame_nxt) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_display_timing_480p.sv
module tb_display_timing_480p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default 640x480 instance
  logic [9:0]  sx_d, sy_d;
  logic        hs_d, vs_d, de_d, fr_d, ln_d;
  logic [15:0] fc_d;
  // Reduced timing: 24 x 14 total, 16 x 8 active, hsync 18..20, vsync 10..11
  logic [9:0]  sx_s, sy_s;
  logic        hs_s, vs_s, de_s, fr_s, ln_s;
  logic [15:0] fc_s;
  // Same reduced timing, positive sync polarity
  logic [9:0]  sx_p, sy_p;
  logic        hs_p, vs_p, de_p, fr_p, ln_p;
  logic [15:0] fc_p;

  display_timing_480p u_def (
    .clk_pix(clk), .rst_pix(rst), .sx(sx_d), .sy(sy_d), .hsync(hs_d), .vsync(vs_d),
    .de(de_d), .frame(fr_d), .line(ln_d), .frame_cnt(fc_d)
  );

  display_timing_480p #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_sml (
    .clk_pix(clk), .rst_pix(rst), .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s),
    .de(de_s), .frame(fr_s), .line(ln_s), .frame_cnt(fc_s)
  );

  display_timing_480p #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .H_POL(1), .V_POL(1)
  ) u_pol (
    .clk_pix(clk), .rst_pix(rst), .sx(sx_p), .sy(sy_p), .hsync(hs_p), .vsync(vs_p),
    .de(de_p), .frame(fr_p), .line(ln_p), .frame_cnt(fc_p)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int k;   // rising edges since reset release
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit fr;
    bit ln;
    int fc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int kk;
    int n_de, n_ln, n_fr, n_hs, n_vs, n_phs, n_pvs, max_x, max_y;
    int first_lo, rehigh, prev_hs, seen;
    bit found, wrapflag;

    tbl[0]  = '{1,   1,  0, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{15,  15, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{16,  16, 0, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{17,  17, 0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{18,  18, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{20,  20, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{21,  21, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{23,  23, 0, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{24,  0,  1, 1, 1, 1, 0, 1, 0};
    tbl[9]  = '{191, 23, 7, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{192, 0,  8, 1, 1, 0, 1, 1, 1};
    tbl[11] = '{193, 1,  8, 1, 1, 0, 0, 0, 1};
    tbl[12] = '{240, 0, 10, 1, 0, 0, 0, 1, 1};
    tbl[13] = '{283, 19, 11, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{288, 0, 12, 1, 1, 0, 0, 1, 1};
    tbl[15] = '{335, 23, 13, 1, 1, 0, 0, 0, 1};
    tbl[16] = '{336, 0,  0, 1, 1, 1, 0, 1, 1};
    tbl[17] = '{337, 1,  0, 1, 1, 1, 0, 0, 1};

    // Reset state
    step();
    step();
    chk("rst sx", int'(sx_s), 0);
    chk("rst sy", int'(sy_s), 0);
    chk("rst hsync", int'(hs_s), 1);
    chk("rst vsync", int'(vs_s), 1);
    chk("rst de", int'(de_s), 0);
    chk("rst frame", int'(fr_s), 0);
    chk("rst line", int'(ln_s), 0);
    chk("rst frame_cnt", int'(fc_s), 0);
    chk("rst pol hsync", int'(hs_p), 0);
    chk("rst pol vsync", int'(vs_p), 0);
    chk("rst def sx", int'(sx_d), 0);
    chk("rst def hsync", int'(hs_d), 1);

    // Table of positions after release
    rst = 1'b0;
    kk = 0;
    for (int i = 0; i < 18; i++) begin
      while (kk < tbl[i].k) begin
        step();
        kk++;
      end
      chk($sformatf("k%0d sx", tbl[i].k), int'(sx_s), tbl[i].x);
      chk($sformatf("k%0d sy", tbl[i].k), int'(sy_s), tbl[i].y);
      chk($sformatf("k%0d hsync", tbl[i].k), int'(hs_s), int'(tbl[i].hs));
      chk($sformatf("k%0d vsync", tbl[i].k), int'(vs_s), int'(tbl[i].vs));
      chk($sformatf("k%0d de", tbl[i].k), int'(de_s), int'(tbl[i].de));
      chk($sformatf("k%0d frame", tbl[i].k), int'(fr_s), int'(tbl[i].fr));
      chk($sformatf("k%0d line", tbl[i].k), int'(ln_s), int'(tbl[i].ln));
      chk($sformatf("k%0d frame_cnt", tbl[i].k), int'(fc_s), tbl[i].fc);
      chk($sformatf("k%0d pol hsync", tbl[i].k), int'(hs_p), int'(!tbl[i].hs));
      chk($sformatf("k%0d pol vsync", tbl[i].k), int'(vs_p), int'(!tbl[i].vs));
    end

    // One full reduced frame: aggregate counts
    n_de = 0; n_ln = 0; n_fr = 0; n_hs = 0; n_vs = 0; n_phs = 0; n_pvs = 0;
    max_x = 0; max_y = 0;
    for (int i = 0; i < 336; i++) begin
      step();
      n_de += int'(de_s);
      n_ln += int'(ln_s);
      n_fr += int'(fr_s);
      n_hs += int'(!hs_s);
      n_vs += int'(!vs_s);
      n_phs += int'(hs_p);
      n_pvs += int'(vs_p);
      if (int'(sx_s) > max_x) max_x = int'(sx_s);
      if (int'(sy_s) > max_y) max_y = int'(sy_s);
    end
    chk("frame de count", n_de, 128);
    chk("frame line count", n_ln, 14);
    chk("frame frame count", n_fr, 1);
    chk("frame hsync low count", n_hs, 42);
    chk("frame vsync low count", n_vs, 48);
    chk("pol hsync high count", n_phs, 42);
    chk("pol vsync high count", n_pvs, 48);
    chk("frame max sx", max_x, 23);
    chk("frame max sy", max_y, 13);
    chk("frame_cnt after 2 frames", int'(fc_s), 2);

    // Asynchronous reset mid-frame, between edges
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (sx_s == 10'd10 && sy_s == 10'd5) found = 1'b1;
      else step();
    end
    chk("reach (10,5)", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async sx", int'(sx_s), 0);
    chk("async sy", int'(sy_s), 0);
    chk("async de", int'(de_s), 0);
    chk("async frame_cnt", int'(fc_s), 0);
    chk("async hsync", int'(hs_s), 1);
    chk("async pol hsync", int'(hs_p), 0);
    chk("async pol vsync", int'(vs_p), 0);
    chk("async def sx", int'(sx_d), 0);
    step();
    chk("held line", int'(ln_s), 0);
    chk("held frame", int'(fr_s), 0);
    chk("held sx", int'(sx_s), 0);
    rst = 1'b0;

    // First default line after release
    n_hs = 0; n_de = 0; n_vs = 0; first_lo = -1; rehigh = -1; prev_hs = 1;
    for (int k = 1; k <= 800; k++) begin
      step();
      if (k == 1) begin
        chk("rel1 sx", int'(sx_s), 1);
        chk("rel1 sy", int'(sy_s), 0);
        chk("rel1 de", int'(de_s), 1);
        chk("rel1 def sx", int'(sx_d), 1);
      end
      if (k == 2) begin
        chk("rel2 sx", int'(sx_s), 2);
        chk("rel2 sy", int'(sy_s), 0);
      end
      if (k == 799) chk("def sx 799", int'(sx_d), 799);
      if (!hs_d) begin
        n_hs++;
        if (first_lo < 0) first_lo = int'(sx_d);
      end
      if (prev_hs == 0 && hs_d && rehigh < 0) rehigh = int'(sx_d);
      prev_hs = int'(hs_d);
      n_de += int'(de_d);
      n_vs += int'(!vs_d);
    end
    chk("def hsync low count", n_hs, 96);
    chk("def hsync first low", first_lo, 656);
    chk("def hsync high again", rehigh, 752);
    chk("def de count", n_de, 640);
    chk("def vsync low count", n_vs, 0);
    chk("def wrap sx", int'(sx_d), 0);
    chk("def wrap sy", int'(sy_d), 1);
    chk("def wrap line", int'(ln_d), 1);

    // frame_cnt wrap, plus (23,13) -> (0,0)
    force u_sml.frame_cnt = 16'hFFFE;
    step();
    release u_sml.frame_cnt;
    chk("forced frame_cnt", int'(fc_s), 16'hFFFE);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (fr_s) found = 1'b1;
    end
    chk("first frame pulse seen", int'(found), 1);
    chk("frame_cnt FFFF", int'(fc_s), 16'hFFFF);
    found = 1'b0;
    wrapflag = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (wrapflag) begin
        chk("wrap to sx 0", int'(sx_s), 0);
        chk("wrap to sy 0", int'(sy_s), 0);
        wrapflag = 1'b0;
        seen++;
      end
      if (sx_s == 10'd23 && sy_s == 10'd13) wrapflag = 1'b1;
      if (fr_s) found = 1'b1;
    end
    chk("second frame pulse seen", int'(found), 1);
    chk("corner wrap observed", seen, 1);
    chk("frame_cnt wrapped", int'(fc_s), 0);
    chk("frame pulse position sy", int'(sy_s), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
